agc_cdu_link: RTL

- AGC-side interface stage, directly downstream of the CDU top-level.
- Consumes the CDU's gimbal-angle increment pulse outputs (ATpPGH/ATmPGH) and accumulates them in a 15-bit two's-complement angle counter for the AGC.
- Produces the drive pulses (AFpPCH/AFmPCH) that the CDU error-angle/DA path consumes, metering out a commanded signed count at a fixed pulse rate.

---
 rtl/agc_cdu_link_pkg.sv | 22 ++
 rtl/agc_cdu_link_pulse_sync_edge.sv | 34 +++
 rtl/agc_cdu_link.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/agc_cdu_link_pkg.sv
// Shared types and helpers for the AGC-side CDU link: FSM states, counter width,
// and ones'-complement drive command decode.
package cdu_link_pkg;

    localparam int CNT_W = 15;

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    typedef struct packed {
        logic             neg;
        logic [CNT_W-1:0] mag;
    } drive_cmd_t;

    // -0 (all ones) decodes to magnitude 0, same as +0.
    function automatic drive_cmd_t decode_cmd(input logic [CNT_W-1:0] word);
        drive_cmd_t c;
        c.neg = word[CNT_W-1];
        c.mag = word[CNT_W-1] ? ~word : word;
        return c;
    endfunction

endpackage

// File: rtl/agc_cdu_link_pulse_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level pulse, followed by an
// edge-detect flop that yields a single-clock strobe on each rising edge.
module pulse_sync_edge
    import cdu_link_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic strobe
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        edge_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
        end
    end

    assign strobe = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/agc_cdu_link.sv
// AGC-side CDU link: accumulates CDU angle increment pulses and meters out a
// signed drive command as fixed-rate AFpPCH/AFmPCH pulses.
//   state | meaning
//   IDLE  | no pulse in flight; may hold a loaded command waiting for drive_en
//   HI    | drive output high, PULSE_WIDTH enabled clocks
//   LO    | inter-pulse gap, PULSE_DIV-PULSE_WIDTH enabled clocks
module agc_cdu_link
    import cdu_link_pkg::*;
#(
    parameter int PULSE_DIV   = 4,
    parameter int PULSE_WIDTH = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLOCKH,
    input  logic             rst,
    input  logic             ATpPGH,
    input  logic             ATmPGH,
    input  logic             cnt_zero,
    input  logic             cmd_load,
    input  logic [CNT_W-1:0] cmd_value,
    input  logic             drive_en,
    output logic [CNT_W-1:0] cdu_count,
    output logic             AFpPCH,
    output logic             AFmPCH,
    output logic             cmd_busy,
    output logic [CNT_W-1:0] cmd_remaining
);

    localparam int PH_W = $clog2(PULSE_DIV);
    localparam logic [PH_W-1:0] HI_LAST = PH_W'(PULSE_WIDTH - 1);
    localparam logic [PH_W-1:0] LO_LAST = PH_W'(PULSE_DIV - PULSE_WIDTH - 1);

    logic inc_stb, dec_stb;

    pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_p (
        .clk(CLOCKH), .rst(rst), .din(ATpPGH), .strobe(inc_stb)
    );

    pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_m (
        .clk(CLOCKH), .rst(rst), .din(ATmPGH), .strobe(dec_stb)
    );

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             dir_q, dir_d;
    logic             pulse_neg_q, pulse_neg_d;
    logic             skip_q, skip_d;
    logic             afp_q, afp_d;
    logic             afm_q, afm_d;
    drive_cmd_t       cmd;
    logic             load_nz;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_zero) begin
            cnt_d = '0;
        end else if (inc_stb && !dec_stb) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_stb && !inc_stb) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        rem_d       = rem_q;
        busy_d      = busy_q;
        dir_d       = dir_q;
        pulse_neg_d = pulse_neg_q;
        skip_d      = skip_q;
        cmd         = decode_cmd(cmd_value);
        load_nz     = cmd_load && (cmd.mag != '0);

        if (cmd_load && !load_nz) begin
            state_d = IDLE;
            phase_d = '0;
            rem_d   = '0;
            busy_d  = 1'b0;
            skip_d  = 1'b0;
        end else begin
            if (load_nz) begin
                rem_d  = cmd.mag;
                dir_d  = cmd.neg;
                busy_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (busy_d && drive_en) begin
                        state_d     = HI;
                        phase_d     = HI_LAST;
                        pulse_neg_d = dir_d;
                        skip_d      = 1'b0;
                    end
                end
                HI: begin
                    // A reload mid-pulse means this pulse belongs to the old command.
                    if (load_nz) skip_d = 1'b1;
                    if (drive_en) begin
                        if (phase_q == '0) begin
                            state_d = LO;
                            phase_d = LO_LAST;
                            skip_d  = 1'b0;
                            if (!load_nz && !skip_q) rem_d = rem_q - CNT_W'(1);
                        end else begin
                            phase_d = phase_q - PH_W'(1);
                        end
                    end
                end
                LO: begin
                    if (drive_en) begin
                        if (phase_q == '0) begin
                            if (rem_d != '0) begin
                                state_d     = HI;
                                phase_d     = HI_LAST;
                                pulse_neg_d = dir_d;
                            end else begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            phase_d = phase_q - PH_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        afp_d = (state_d == HI) && !pulse_neg_d;
        afm_d = (state_d == HI) && pulse_neg_d;
    end

    always_ff @(posedge CLOCKH or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            dir_q       <= 1'b0;
            pulse_neg_q <= 1'b0;
            skip_q      <= 1'b0;
            afp_q       <= 1'b0;
            afm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            busy_q      <= busy_d;
            dir_q       <= dir_d;
            pulse_neg_q <= pulse_neg_d;
            skip_q      <= skip_d;
            afp_q       <= afp_d;
            afm_q       <= afm_d;
        end
    end

    assign cdu_count     = cnt_q;
    assign AFpPCH        = afp_q;
    assign AFmPCH        = afm_q;
    assign cmd_busy      = busy_q;
    assign cmd_remaining = rem_q;

endmodule
